multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mc_aludec.sv | 25 ++
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// The optional addi support is enabled by defining MC_ADDI_EN.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
`ifdef MC_ADDI_EN
        S_JUMP,
        S_ADDIEXEC,
        S_ADDIWB
`else
        S_JUMP
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ASB_B     = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_IMM   = 2'b10;
    localparam logic [1:0] ASB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// R-type function decoder: maps funct to an ALU operation
// and flags function codes the datapath cannot execute.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    // Pure lookup; unknown funct defaults to add and raises illegal
    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with state-decoded datapath controls.
// Define MC_ADDI_EN to add the ADDIEXEC/ADDIWB path for addi.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_ctl;
    logic       w_alu_bad;

    mc_aludec u_aludec (
        .funct      (funct),
        .alucontrol (w_alu_ctl),
        .illegal    (w_alu_bad)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // Next-state and control decode; strobes are gated off in reset
    always_comb begin
        w_next     = r_state;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ASB_B;
        alucontrol = ALU_ADD;
        pcsrc      = PCS_ALU;
        pcen       = 1'b0;
        illegal_op = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = ASB_FOUR;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = ASB_IMMSH;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_next = S_ADDIEXEC;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ASB_IMM;
                if (op == OP_SW)      w_next = S_MEMWR;
                else if (op == OP_LW) w_next = S_MEMRD;
                else                  w_next = S_FETCH;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_alu_ctl;
                if (w_alu_bad) begin
                    illegal_op = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next     = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PCS_ALUOUT;
                pcen       = zero;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = PCS_JUMP;
                pcen   = 1'b1;
                w_next = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = ASB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
        if (!reset_n) begin
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
